// File: rtl/im_cache_pool_sched.sv
`default_nettype none
// ============================================================================
// im_cache_pool_sched : grants the 4-bank pooling cache to the writer for N
// passes, drains, then walks every 2x2 neighbourhood with per-bank masks.
// Revision 1.0
// ============================================================================
module im_cache_pool_sched #(
  parameter int IM_CACHE_ADDR_WIDTH = 10,
  parameter int DIM_WIDTH           = 9,
  parameter int PASS_WIDTH          = 10,
  parameter int IM_CACHE_DELAY      = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DIM_WIDTH-1:0]           max_row_in,
  input  logic [DIM_WIDTH-1:0]           max_col_in,
  input  logic [PASS_WIDTH-1:0]          pass_count_in,
  input  logic                           params_valid_in,
  input  logic                           wr_last_in,
  output logic                           wr_grant_out,
  input  logic                           pool_stall_in,
  output logic [IM_CACHE_ADDR_WIDTH-1:0] pool_rd_addr_out,
  output logic [3:0]                     pool_rd_sel_out,
  output logic                           pool_data_valid_out,
  output logic [3:0]                     pool_mask_out,
  output logic                           pool_last_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           err_out
);

  localparam int CNT_W = (IM_CACHE_DELAY < 2) ? 1 : $clog2(IM_CACHE_DELAY);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(IM_CACHE_DELAY - 1);
  localparam logic [DIM_WIDTH:0] ONE_W = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t state, state_next;

  logic [DIM_WIDTH-1:0]           max_row, max_col;
  logic [PASS_WIDTH-1:0]          pass_target, pass_cnt;
  logic [DIM_WIDTH-1:0]           pool_rows, pool_cols, prow, pcol;
  logic [IM_CACHE_ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_W-1:0]               dcnt;
  logic [3:0]                     iss_mask;
  logic                           iss_last;
  logic [IM_CACHE_DELAY-1:0]      v_pipe, l_pipe;
  logic [3:0]                     m_pipe [IM_CACHE_DELAY];

  logic                           accept, pass_hit, delay_done, issue;
  logic                           col_end, row_end, nbh_last;
  logic [DIM_WIDTH:0]             col_odd, row_odd;
  logic [3:0]                     nbh_mask;

  assign accept     = (state == IDLE) && params_valid_in;
  assign pass_hit   = wr_last_in && ((pass_cnt + PASS_WIDTH'(1)) == pass_target);
  assign delay_done = (dcnt == DLY_LAST);
  assign issue      = (state == READ) && !pool_stall_in;
  assign col_end    = (pcol == pool_cols - DIM_WIDTH'(1));
  assign row_end    = (prow == pool_rows - DIM_WIDTH'(1));
  assign nbh_last   = row_end && col_end;

  // Odd source row/col of the neighbourhood exists only if it is inside the image
  assign col_odd     = {pcol, 1'b1};
  assign row_odd     = {prow, 1'b1};
  assign nbh_mask[0] = 1'b1;
  assign nbh_mask[1] = (col_odd < {1'b0, max_col});
  assign nbh_mask[2] = (row_odd < {1'b0, max_row});
  assign nbh_mask[3] = nbh_mask[1] & nbh_mask[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (params_valid_in) state_next = LOAD;
      LOAD:    state_next = WRITE;
      WRITE:   if (pass_hit) state_next = DRAIN;
      DRAIN:   if (delay_done) state_next = READ;
      READ:    if (issue && nbh_last) state_next = FLUSH;
      FLUSH:   if (delay_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_row     <= '0;
      max_col     <= '0;
      pass_target <= '0;
      pass_cnt    <= '0;
      pool_rows   <= '0;
      pool_cols   <= '0;
      prow        <= '0;
      pcol        <= '0;
      rd_addr     <= '0;
      dcnt        <= '0;
    end else begin
      case (state)
        IDLE: if (params_valid_in) begin
          max_row     <= max_row_in;
          max_col     <= max_col_in;
          pass_target <= (pass_count_in == '0) ? PASS_WIDTH'(1) : pass_count_in;
        end
        LOAD: begin
          pool_rows <= DIM_WIDTH'(({1'b0, max_row} + ONE_W) >> 1);
          pool_cols <= DIM_WIDTH'(({1'b0, max_col} + ONE_W) >> 1);
          pass_cnt  <= '0;
          prow      <= '0;
          pcol      <= '0;
          rd_addr   <= '0;
          dcnt      <= '0;
        end
        WRITE: if (wr_last_in) pass_cnt <= pass_cnt + PASS_WIDTH'(1);
        DRAIN, FLUSH: dcnt <= delay_done ? '0 : dcnt + CNT_W'(1);
        // Row-major address advances by one, so prow*pool_cols+pcol needs no multiplier
        READ: if (issue) begin
          rd_addr <= rd_addr + IM_CACHE_ADDR_WIDTH'(1);
          if (col_end) begin
            pcol <= '0;
            prow <= prow + DIM_WIDTH'(1);
          end else begin
            pcol <= pcol + DIM_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_grant_out     <= 1'b0;
      busy_out         <= 1'b0;
      pool_rd_addr_out <= '0;
      pool_rd_sel_out  <= 4'b0000;
      iss_mask         <= 4'b0000;
      iss_last         <= 1'b0;
      done_out         <= 1'b0;
      err_out          <= 1'b0;
      v_pipe           <= '0;
      l_pipe           <= '0;
      for (int i = 0; i < IM_CACHE_DELAY; i++) m_pipe[i] <= 4'b0000;
    end else begin
      wr_grant_out    <= (state_next == WRITE);
      busy_out        <= (state_next != IDLE);
      pool_rd_sel_out <= issue ? 4'b1111 : 4'b0000;
      iss_mask        <= issue ? nbh_mask : 4'b0000;
      iss_last        <= issue && nbh_last;
      if (issue) pool_rd_addr_out <= rd_addr;
      done_out        <= (state == FLUSH) && delay_done;
      err_out         <= (accept ? 1'b0 : err_out) | (wr_last_in && (state != WRITE));
      // Side-band follows the bank read through the cache latency
      v_pipe[0] <= |pool_rd_sel_out;
      m_pipe[0] <= iss_mask;
      l_pipe[0] <= iss_last;
      for (int i = 1; i < IM_CACHE_DELAY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        m_pipe[i] <= m_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
    end
  end

  assign pool_data_valid_out = v_pipe[IM_CACHE_DELAY-1];
  assign pool_mask_out       = m_pipe[IM_CACHE_DELAY-1];
  assign pool_last_out       = l_pipe[IM_CACHE_DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_im_cache_pool_sched.sv
`default_nettype none
// ============================================================================
// tb_im_cache_pool_sched : directed self-checking bench for im_cache_pool_sched
// Revision 1.0
// ============================================================================
module tb_im_cache_pool_sched;

  localparam int D = 2;

  logic       clk;
  logic       reset_n;
  logic [8:0] max_row_in, max_col_in;
  logic [9:0] pass_count_in;
  logic       params_valid_in, wr_last_in, pool_stall_in;
  logic       wr_grant_out, pool_data_valid_out, pool_last_out;
  logic       busy_out, done_out, err_out;
  logic [9:0] pool_rd_addr_out;
  logic [3:0] pool_rd_sel_out, pool_mask_out;

  im_cache_pool_sched #(
    .IM_CACHE_ADDR_WIDTH(10), .DIM_WIDTH(9), .PASS_WIDTH(10), .IM_CACHE_DELAY(D)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .max_row_in(max_row_in), .max_col_in(max_col_in),
    .pass_count_in(pass_count_in), .params_valid_in(params_valid_in),
    .wr_last_in(wr_last_in), .wr_grant_out(wr_grant_out),
    .pool_stall_in(pool_stall_in), .pool_rd_addr_out(pool_rd_addr_out),
    .pool_rd_sel_out(pool_rd_sel_out), .pool_data_valid_out(pool_data_valid_out),
    .pool_mask_out(pool_mask_out), .pool_last_out(pool_last_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_fail;
  int cyc, done_cnt, done_cyc, last_wr_cyc;
  int         iss_addr[$];
  int         iss_cyc[$];
  logic [3:0] v_mask[$];
  logic       v_last[$];

  // Passive recorder sampled on the inactive edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pool_rd_sel_out != 4'b0000) begin
      iss_addr.push_back(int'(pool_rd_addr_out));
      iss_cyc.push_back(cyc);
    end
    if (pool_data_valid_out) begin
      v_mask.push_back(pool_mask_out);
      v_last.push_back(pool_last_out);
    end
    if (wr_last_in) last_wr_cyc = cyc;
    if (done_out) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_rec();
    iss_addr.delete(); iss_cyc.delete(); v_mask.delete(); v_last.delete();
  endtask

  task automatic start_job(input int r, input int c, input int p);
    @(posedge clk); #1;
    max_row_in = r[8:0]; max_col_in = c[8:0]; pass_count_in = p[9:0];
    params_valid_in = 1'b1;
    @(posedge clk); #1;
    params_valid_in = 1'b0;
  endtask

  task automatic pulse_last();
    repeat (3) @(posedge clk);
    #1 wr_last_in = 1'b1;
    @(posedge clk);
    #1 wr_last_in = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic wait_first_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pool_rd_sel_out != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_grant_out, pool_rd_addr_out, pool_rd_sel_out, pool_data_valid_out, pool_mask_out,
         pool_last_out, busy_out, done_out, err_out} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b addr=%0d sel=%b v=%b m=%b l=%b busy=%b done=%b err=%b, want all 0",
               wr_grant_out, pool_rd_addr_out, pool_rd_sel_out, pool_data_valid_out, pool_mask_out,
               pool_last_out, busy_out, done_out, err_out);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    clear_rec();
    start_job(4, 4, 1);
    pulse_last();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done: got no done_out, want done"); end
    n_cmp++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL basic_issue_count: got %0d want 4", iss_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      int a; logic [3:0] m; logic l;
      a = (i < iss_addr.size()) ? iss_addr[i] : -1;
      m = (i < v_mask.size()) ? v_mask[i] : 4'bxxxx;
      l = (i < v_last.size()) ? v_last[i] : 1'bx;
      n_cmp++; if (a != i) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, a, i); end
      n_cmp++; if (m !== 4'b1111) begin n_fail++; $display("FAIL basic_mask[%0d]: got %b want 1111", i, m); end
      n_cmp++; if (l !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b want %b", i, l, (i == 3)); end
    end
    n_cmp++;
    if (iss_cyc.size() == 0 || (iss_cyc[0] - last_wr_cyc) != D + 2) begin
      n_fail++; $display("FAIL basic_first_issue_latency: got %0d want %0d",
                         (iss_cyc.size() > 0) ? iss_cyc[0] - last_wr_cyc : -1, D + 2);
    end
    n_cmp++;
    if (iss_cyc.size() == 0 || (done_cyc - iss_cyc[iss_cyc.size()-1]) != D) begin
      n_fail++; $display("FAIL basic_done_latency: got %0d want %0d",
                         (iss_cyc.size() > 0) ? done_cyc - iss_cyc[iss_cyc.size()-1] : -1, D);
    end
  endtask

  task automatic test_odd_dims();
    bit ok;
    logic [3:0] em [6];
    em = '{4'b1111, 4'b0101, 4'b1111, 4'b0101, 4'b0011, 4'b0001};
    clear_rec();
    start_job(5, 3, 1);
    pulse_last();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL odd_done: got no done_out, want done"); end
    n_cmp++; if (v_mask.size() != 6) begin n_fail++; $display("FAIL odd_beats: got %0d want 6", v_mask.size()); end
    for (int i = 0; i < 6; i++) begin
      int a; logic [3:0] m; logic l;
      a = (i < iss_addr.size()) ? iss_addr[i] : -1;
      m = (i < v_mask.size()) ? v_mask[i] : 4'bxxxx;
      l = (i < v_last.size()) ? v_last[i] : 1'bx;
      n_cmp++; if (a != i) begin n_fail++; $display("FAIL odd_addr[%0d]: got %0d want %0d", i, a, i); end
      n_cmp++; if (m !== em[i]) begin n_fail++; $display("FAIL odd_mask[%0d]: got %b want %b", i, m, em[i]); end
      n_cmp++; if (l !== (i == 5)) begin n_fail++; $display("FAIL odd_last[%0d]: got %b want %b", i, l, (i == 5)); end
    end
  endtask

  task automatic test_multi_pass();
    bit ok;
    clear_rec();
    start_job(4, 4, 3);
    pulse_last();
    pulse_last();
    n_cmp++; if (wr_grant_out !== 1'b1) begin n_fail++; $display("FAIL mp_grant_held: got %b want 1", wr_grant_out); end
    n_cmp++; if (iss_addr.size() != 0) begin n_fail++; $display("FAIL mp_early_issue: got %0d issues want 0", iss_addr.size()); end
    pulse_last();
    n_cmp++; if (wr_grant_out !== 1'b0) begin n_fail++; $display("FAIL mp_grant_drop: got %b want 0", wr_grant_out); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mp_done: got no done_out, want done"); end
    n_cmp++;
    if (iss_cyc.size() != 4 || (iss_cyc[0] - last_wr_cyc) != D + 2) begin
      n_fail++; $display("FAIL mp_read_after_drain: got %0d issues, first at +%0d, want 4 at +%0d",
                         iss_cyc.size(), (iss_cyc.size() > 0) ? iss_cyc[0] - last_wr_cyc : -1, D + 2);
    end
  endtask

  task automatic test_stall();
    bit ok, okd;
    clear_rec();
    start_job(4, 4, 1);
    pulse_last();
    wait_first_issue(ok);
    @(posedge clk); #1 pool_stall_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 pool_stall_in = 1'b0;
    wait_done(okd);
    n_cmp++; if ((ok & okd) !== 1'b1) begin n_fail++; $display("FAIL stall_progress: got issue=%b done=%b want 1/1", ok, okd); end
    n_cmp++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL stall_issue_count: got %0d want 4", iss_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      int a;
      a = (i < iss_addr.size()) ? iss_addr[i] : -1;
      n_cmp++; if (a != i) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, a, i); end
    end
    n_cmp++; if (v_mask.size() != 4) begin n_fail++; $display("FAIL stall_beats: got %0d want 4", v_mask.size()); end
    n_cmp++;
    if (iss_cyc.size() != 4 || (iss_cyc[3] - iss_cyc[0]) != 6) begin
      n_fail++; $display("FAIL stall_span: got %0d want 6", (iss_cyc.size() == 4) ? iss_cyc[3] - iss_cyc[0] : -1);
    end
  endtask

  task automatic test_errors();
    bit ok, okd;
    @(posedge clk); #1 wr_last_in = 1'b1;
    @(posedge clk); #1 wr_last_in = 1'b0;
    n_cmp++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_set_idle: got %b want 1", err_out); end
    clear_rec();
    start_job(4, 4, 1);
    n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_params: got %b want 0", err_out); end
    pulse_last();
    wait_first_issue(ok);
    @(posedge clk); #1;
    max_row_in = 9'd1; max_col_in = 9'd1; params_valid_in = 1'b1;
    @(posedge clk); #1 params_valid_in = 1'b0;
    wait_done(okd);
    n_cmp++; if ((ok & okd) !== 1'b1) begin n_fail++; $display("FAIL ign_progress: got issue=%b done=%b want 1/1", ok, okd); end
    n_cmp++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL ign_issue_count: got %0d want 4", iss_addr.size()); end
    n_cmp++;
    if (iss_addr.size() != 4 || iss_addr[3] != 3) begin
      n_fail++; $display("FAIL ign_last_addr: got %0d want 3", (iss_addr.size() > 0) ? iss_addr[iss_addr.size()-1] : -1);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL ign_no_new_job: busy got %b want 0", busy_out); end
    n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL ign_err_clean: got %b want 0", err_out); end
  endtask

  task automatic test_one_by_one();
    bit ok;
    clear_rec();
    start_job(1, 1, 0);
    pulse_last();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL one_done: got no done_out, want done"); end
    n_cmp++;
    if (iss_addr.size() != 1 || iss_addr[0] != 0) begin
      n_fail++; $display("FAIL one_issue: got %0d issues, want one at addr 0", iss_addr.size());
    end
    n_cmp++;
    if (v_mask.size() != 1 || v_mask[0] !== 4'b0001 || v_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL one_beat: got %0d beats mask=%b, want 1 beat mask 0001 last 1",
                         v_mask.size(), (v_mask.size() > 0) ? v_mask[0] : 4'bxxxx);
    end
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    int d0;
    clear_rec();
    start_job(4, 4, 1);
    pulse_last();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pool_rd_sel_out != 4'b0000 && pool_rd_addr_out == 10'd2) begin found = 1'b1; break; end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_addr2: got not reached want reached"); end
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_grant_out, pool_rd_addr_out, pool_rd_sel_out, pool_data_valid_out, pool_mask_out,
         pool_last_out, busy_out, done_out, err_out} !== 25'd0) begin
      n_fail++; $display("FAIL rmid_async_clear: got addr=%0d sel=%b v=%b busy=%b, want all 0",
                         pool_rd_addr_out, pool_rd_sel_out, pool_data_valid_out, busy_out);
    end
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d done pulses want 0", done_cnt - d0); end
    clear_rec();
    start_job(4, 4, 1);
    pulse_last();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_rerun_done: got no done_out, want done"); end
    for (int i = 0; i < 4; i++) begin
      int a;
      a = (i < iss_addr.size()) ? iss_addr[i] : -1;
      n_cmp++; if (a != i) begin n_fail++; $display("FAIL rmid_rerun_addr[%0d]: got %0d want %0d", i, a, i); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    cyc = 0; done_cnt = 0; done_cyc = 0; last_wr_cyc = 0;
    reset_n = 1'b0;
    max_row_in = '0; max_col_in = '0; pass_count_in = '0;
    params_valid_in = 1'b0; wr_last_in = 1'b0; pool_stall_in = 1'b0;
    test_reset();
    test_basic();
    test_odd_dims();
    test_multi_pass();
    test_stall();
    test_errors();
    test_one_by_one();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/im_cache_pool_sched.md
# im_cache_pool_sched

Sequencing controller for the 4-bank pooling image cache. It grants the cache to the cache writer for a configured number of accumulation passes and counts the writer's last-write pulses. It then drains in-flight writes and walks every 2x2 neighbourhood address, reading all four banks in parallel. Read data goes to the max-pool stage with per-bank edge masks for odd dimensions. It sits between the layer control registers, the cache writer and the pooling datapath.

## Interface
- IM_CACHE_ADDR_WIDTH, 10, cache bank address width
- DIM_WIDTH, 9, row/col dimension width
- PASS_WIDTH, 10, accumulation pass counter width
- IM_CACHE_DELAY, 2, cache read latency in cycles (>=1)
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- max_row_in  in  DIM_WIDTH  filter output rows (>=1)
- max_col_in  in  DIM_WIDTH  filter output cols (>=1)
- pass_count_in  in  PASS_WIDTH  accumulation passes; 0 treated as 1
- params_valid_in  in  1  parameter strobe, accepted only in IDLE
- wr_last_in  in  1  last-write pulse from cache writer
- wr_grant_out  out  1  writer owns the cache
- pool_stall_in  in  1  downstream almost-full; halts read issue
- pool_rd_addr_out  out  IM_CACHE_ADDR_WIDTH  bank read address
- pool_rd_sel_out  out  4  bank read select (4'b1111 while issuing)
- pool_data_valid_out  out  1  cache data on bank outputs is valid
- pool_mask_out  out  4  per-bank validity, aligned with pool_data_valid_out
- pool_last_out  out  1  final neighbourhood, aligned with pool_data_valid_out
- busy_out  out  1  not IDLE
- done_out  out  1  one-cycle completion pulse
- err_out  out  1  sticky: wr_last_in seen outside WRITE; cleared on accepted params

## Operation
- States: IDLE, LOAD, WRITE, DRAIN, READ, FLUSH.
- IDLE: on params_valid_in, latch the inputs and go to LOAD.
- LOAD (1 cycle): compute pool_rows = ceil(max_row/2) and pool_cols = ceil(max_col/2). Clear the pass counter, row/col counters and address. Go to WRITE.
- WRITE: wr_grant_out=1. Each wr_last_in increments the pass counter. When the count reaches the effective pass count, go to DRAIN in the next cycle.
- DRAIN: wr_grant_out=0. Wait IM_CACHE_DELAY cycles, then go to READ.
- READ, each cycle with pool_stall_in=0:
  - issue pool_rd_addr_out = prow*pool_cols + pcol, maintained incrementally (address +1), no multiplier;
  - pool_rd_sel_out = 4'b1111;
  - advance pcol, wrapping to 0 and incrementing prow.
- READ, each cycle with pool_stall_in=1: pool_rd_sel_out = 0 and all counters hold.
- Issuing prow = pool_rows-1, pcol = pool_cols-1 moves to FLUSH.
- FLUSH: wait IM_CACHE_DELAY cycles so the valid pipeline empties. Pulse done_out and return to IDLE.
- Mask for neighbourhood (prow, pcol):
  - bit0 = 1;
  - bit1 = (2*pcol+1 < max_col);
  - bit2 = (2*prow+1 < max_row);
  - bit3 = bit1 & bit2.
- Bank order matches the writer: 0 = even row/even col, 1 = even/odd, 2 = odd/even, 3 = odd/odd.
- params_valid_in outside IDLE is ignored. Parameters stay stable from LOAD until IDLE.
- Widths: internal dim math uses DIM_WIDTH+1 bits. The product pool_rows*pool_cols must fit IM_CACHE_ADDR_WIDTH; the controller does not check this.

## Timing
- Reset (async assert, sync deassert by system): state IDLE.
- Reset values: every output 0, including err_out. The valid/mask/last shift pipeline clears.
- Reset mid-operation aborts immediately with no done_out.
- Outputs are registered.
- pool_rd_addr_out/pool_rd_sel_out update one cycle after the state/counter decision.
- pool_data_valid_out/mask/last equal the issue-cycle sel-nonzero/mask/last delayed by exactly IM_CACHE_DELAY cycles.
- pool_stall_in is sampled each cycle in READ and takes effect on the next issued output. Downstream must tolerate IM_CACHE_DELAY+1 data beats after asserting stall.
- wr_last_in in the same cycle as the WRITE->DRAIN decision cannot occur: the writer only pulses once per pass. Extra pulses in DRAIN/READ/FLUSH/IDLE/LOAD set err_out and are otherwise ignored.
- Minimum job latency from params_valid_in: 1 (LOAD) + WRITE duration + IM_CACHE_DELAY + pool_rows*pool_cols + IM_CACHE_DELAY cycles, plus 1 to done_out.
- 1x1 image: READ lasts one cycle, mask 4'b0001, last=1.

## Test plan
- 4x4, 1 pass, no stall, one wr_last:
  - 4 issues at addr 0,1,2,3, all with mask 1111;
  - pool_last_out on the 4th valid beat;
  - done_out IM_CACHE_DELAY+1 cycles after the last issue.
- 5x3, 1 pass: pool dims 3x2, addr 0..5.
  - masks row0: 1111, 0101;
  - masks row1: 1111, 0101;
  - masks row2: 0011, 0001.
- 4x4, pass_count_in=3:
  - wr_grant_out stays high until the 3rd wr_last_in;
  - no read issued before it plus IM_CACHE_DELAY cycles.
- 4x4 with pool_stall_in high for 3 cycles mid-READ:
  - addresses still 0..3 in order, no duplicates or skips;
  - valid beats count exactly 4.
- Error and ignore cases:
  - wr_last_in while IDLE sets err_out=1;
  - params_valid_in during READ is ignored;
  - next accepted params clears err_out.
- reset_n low during READ at addr 2:
  - all outputs 0 asynchronously, no done_out;
  - a new job afterwards runs normally from addr 0.
